// File: rtl/fib_arbiter.sv
// fib_arbiter: two requesters share one iterative Fibonacci engine.
// A round-robin arbiter grants one requester, the engine runs one adder
// iteration per clock, and the owner gets a one-cycle done pulse with the
// result held on result_o until the next completion.
//
// Handshake: a requester raises req_i[k] and holds it high until it sees
// gnt_o[k] for one cycle; its index nK_i is sampled on that grant edge.
// done_o[k] pulses for one cycle when result_o/ovf_o are valid for it.
// req_i is ignored while busy_o is high. busy_o is the FSM state (RUN).
module fib_arbiter #(
  parameter int WIDTH = 32,
  parameter int MAX_N = 47
) (
  input  logic             clk,
  input  logic             reset_button,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] n0_i,
  input  logic [WIDTH-1:0] n1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] MaxNW = WIDTH'(MAX_N);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             pick;

  // Round-robin pick: a lone request wins; on a tie the one not served last wins.
  always_comb begin
    pick = 1'b0;
    case (req_i)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_q;
      default: pick = 1'b0;
    endcase
  end

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    owner_d  = owner_q;
    last_d   = last_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          owner_d = pick;
          cnt_d   = pick ? n1_i : n0_i;
          a_d     = '0;
          b_d     = {{(WIDTH-1){1'b0}}, 1'b1};
          gnt_d   = pick ? 2'b10 : 2'b01;
          state_d = RUN;
        end
      end
      RUN: begin
        // cnt only decrements from a value <= MAX_N, so this can only
        // fire on the first RUN edge of an out-of-range request.
        if (cnt_q > MaxNW) begin
          result_d = '1;
          ovf_d    = 1'b1;
          done_d   = owner_q ? 2'b10 : 2'b01;
          last_d   = owner_q;
          state_d  = IDLE;
        end else if (cnt_q != '0) begin
          a_d   = b_q;
          b_d   = a_q + b_q;
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d = a_q;
          ovf_d    = 1'b0;
          done_d   = owner_q ? 2'b10 : 2'b01;
          last_d   = owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction silently.
  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign ovf_o    = ovf_q;
  assign busy_o   = (state_q == RUN);

endmodule

// File: tb/tb_fib_arbiter.sv
// Directed bench for fib_arbiter: transaction tasks with literal expected
// results and latencies, plus a cycle-level reference model compared on
// every negative clock edge.
module tb_fib_arbiter;
  localparam int W    = 32;
  localparam int MAXN = 47;

  logic         clk = 1'b0;
  logic         reset_button = 1'b0;
  logic [1:0]   req_i = 2'b00;
  logic [W-1:0] n0_i = '0;
  logic [W-1:0] n1_i = '0;
  logic [1:0]   gnt_o, done_o;
  logic [W-1:0] result_o;
  logic         ovf_o, busy_o;

  int n_vec  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  fib_arbiter #(.WIDTH(W), .MAX_N(MAXN)) dut (
    .clk(clk), .reset_button(reset_button), .req_i(req_i),
    .n0_i(n0_i), .n1_i(n1_i), .gnt_o(gnt_o), .done_o(done_o),
    .result_o(result_o), .ovf_o(ovf_o), .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference Fibonacci by plain iteration, modulo 2^W.
  function automatic logic [W-1:0] fib_ref(input int unsigned n);
    logic [W-1:0] x, y, t;
    x = '0;
    y = 1;
    for (int unsigned i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference model: a grant schedules a completion a fixed number of
  // cycles later (n+1, or 1 when out of range) carrying the precomputed value.
  int           m_rem;
  logic [1:0]   m_gnt, m_done;
  logic [W-1:0] m_res, m_val;
  logic         m_ovf, m_o, m_own, m_last;

  always @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      m_rem = 0; m_gnt = 0; m_done = 0; m_res = 0; m_ovf = 0;
      m_val = 0; m_o = 0; m_own = 0; m_last = 1;
    end else begin
      logic [W-1:0] n;
      m_gnt  = 2'b00;
      m_done = 2'b00;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = (m_own ? 2'b10 : 2'b01);
          m_res  = m_val;
          m_ovf  = m_o;
          m_last = m_own;
        end
      end else if (req_i != 2'b00) begin
        if (req_i == 2'b11) m_own = ~m_last;
        else                m_own = req_i[1];
        n     = m_own ? n1_i : n0_i;
        m_o   = (n > MAXN);
        m_val = m_o ? '1 : fib_ref(int'(n));
        m_rem = m_o ? 1 : int'(n) + 1;
        m_gnt = (m_own ? 2'b10 : 2'b01);
      end
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (started && !reset_button) begin
      check("gnt_o",    64'(gnt_o),    64'(m_gnt));
      check("done_o",   64'(done_o),   64'(m_done));
      check("busy_o",   64'(busy_o),   64'(m_rem > 0));
      check("result_o", 64'(result_o), 64'(m_res));
      check("ovf_o",    64'(ovf_o),    64'(m_ovf));
    end
  end

  // Reset pulse; outputs must clear immediately, before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_button = 1'b1;
    #1;
    check("rst gnt_o",    64'(gnt_o),    64'd0);
    check("rst done_o",   64'(done_o),   64'd0);
    check("rst result_o", 64'(result_o), 64'd0);
    check("rst ovf_o",    64'(ovf_o),    64'd0);
    check("rst busy_o",   64'(busy_o),   64'd0);
    repeat (2) @(negedge clk);
    #2 reset_button = 1'b0;
    started = 1'b1;
  endtask

  task automatic raise(input logic [1:0] r, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    n0_i  = a;
    n1_i  = b;
    req_i = req_i | r;
  endtask

  // Wait for a grant, check which bit, then drop that request.
  task automatic wait_grant(input logic [1:0] exp_gnt);
    int k = 0;
    @(negedge clk);
    while (gnt_o == 2'b00 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (gnt_o == 2'b00) begin
      n_vec++; n_fail++;
      $display("FAIL grant timeout: got none expected 0x%0h", exp_gnt);
    end else begin
      check("grant owner", 64'(gnt_o), 64'(exp_gnt));
      req_i = req_i & ~gnt_o;
    end
  endtask

  // Count cycles from the grant cycle to the done pulse, check result.
  task automatic wait_done(input logic [1:0] exp_done, input logic [W-1:0] exp_res,
                           input logic exp_ovf, input int exp_lat);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done_o == 2'b00 && k < 80);
    if (done_o == 2'b00) begin
      n_vec++; n_fail++;
      $display("FAIL done timeout: got none expected 0x%0h", exp_done);
    end else begin
      check("done owner", 64'(done_o),   64'(exp_done));
      check("latency",    64'(k),        64'(exp_lat));
      check("result",     64'(result_o), 64'(exp_res));
      check("ovf",        64'(ovf_o),    64'(exp_ovf));
    end
  endtask

  task automatic one_txn(input logic [1:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input logic exp_ovf, input int exp_lat);
    raise(r, a, b);
    wait_grant(r);
    wait_done(r, exp_res, exp_ovf, exp_lat);
  endtask

  initial begin
    #3;
    do_reset();
    // n0=10: 11 busy cycles, result 55
    one_txn(2'b01, 32'd10, 32'd0, 32'd55, 1'b0, 11);

    // Simultaneous requests from reset: 0 then 1, then 0 again
    do_reset();
    raise(2'b11, 32'd5, 32'd7);
    wait_grant(2'b01);
    wait_done(2'b01, 32'd5, 1'b0, 6);
    wait_grant(2'b10);
    wait_done(2'b10, 32'd13, 1'b0, 8);
    raise(2'b11, 32'd5, 32'd7);
    wait_grant(2'b01);
    wait_done(2'b01, 32'd5, 1'b0, 6);
    wait_grant(2'b10);
    wait_done(2'b10, 32'd13, 1'b0, 8);

    // Smallest indices
    one_txn(2'b01, 32'd0, 32'd0, 32'd0, 1'b0, 1);
    one_txn(2'b01, 32'd1, 32'd0, 32'd1, 1'b0, 2);

    // Range boundary on requester 1, then overflow on both
    one_txn(2'b10, 32'd0, 32'd47, 32'hB11924E1, 1'b0, 48);
    one_txn(2'b10, 32'd0, 32'd48, 32'hFFFFFFFF, 1'b1, 1);
    one_txn(2'b01, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b1, 1);
    // A valid result clears ovf again
    one_txn(2'b01, 32'd2, 32'd0, 32'd1, 1'b0, 3);

    // Reset mid-run aborts; re-request completes normally
    raise(2'b01, 32'd20, 32'd0);
    wait_grant(2'b01);
    repeat (5) @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);
    check("no done after abort", 64'(done_o), 64'd0);
    one_txn(2'b01, 32'd20, 32'd0, 32'd6765, 1'b0, 21);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
